// File: rtl/core_sequencer_pkg.sv
// core_pkg: shared state encodings and constants for the multi-cycle core sequencer.
// Rev 1.0
`default_nettype none

package core_pkg;

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_MEMORY    = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;

  typedef enum logic [2:0] {
    S_FETCH     = ST_FETCH,
    S_DECODE    = ST_DECODE,
    S_EXECUTE   = ST_EXECUTE,
    S_MEMORY    = ST_MEMORY,
    S_WRITEBACK = ST_WRITEBACK
  } state_t;

  // addi x0,x0,0: a zero word would decode as a load
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: instruction and data memory request/ready handshakes.
// Rev 1.0
`default_nettype none

interface core_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_data,
    output dmem_req, dmem_we, dmem_addr,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_data,
    input  dmem_req, dmem_we, dmem_addr,
    output dmem_ready, dmem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/core_sequencer_pc_next_unit.sv
// pc_next_unit: combinational next-PC select (taken branch / jump target, else pc+4).
// Rev 1.0
`default_nettype none

module pc_next_unit (
  input  wire logic [31:0] pc,
  input  wire logic [31:0] target_addr,
  input  wire logic        should_jump,
  input  wire logic        should_branch,
  input  wire logic        branch_taken,
  output logic      [31:0] next_pc
);

  logic redirect;

  assign redirect = should_jump | (should_branch & branch_taken);
  // targets are forced word-aligned; sequential path wraps modulo 2^32
  assign next_pc  = redirect ? {target_addr[31:2], 2'b00} : (pc + 32'd4);

endmodule

`default_nettype wire

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute/memory/writeback control FSM.
// Rev 1.0
`default_nettype none

module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  core_sequencer_if.master mem,
  output logic      [31:0] instr,
  input  wire logic        should_read_mem,
  input  wire logic        should_write_mem,
  input  wire logic        should_write_reg,
  input  wire logic        should_branch,
  input  wire logic        should_jump,
  input  wire logic [31:0] alu_result,
  input  wire logic        branch_taken,
  input  wire logic [31:0] target_addr,
  output logic      [31:0] alu_out,
  output logic      [31:0] load_data,
  output logic             reg_we,
  output logic             wb_sel,
  output logic      [31:0] pc,
  output logic             retire,
  output logic      [2:0]  state
);

  state_t      cur_state;
  state_t      nxt_state;
  logic        imem_req_raw;
  logic        dmem_req_raw;
  logic        reg_we_raw;
  logic        retire_raw;
  logic [31:0] pc_next;

  pc_next_unit u_pc_next (
    .pc            (pc),
    .target_addr   (target_addr),
    .should_jump   (should_jump),
    .should_branch (should_branch),
    .branch_taken  (branch_taken),
    .next_pc       (pc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_FETCH;
      pc        <= RESET_PC;
      instr     <= NOP_INSTR;
      alu_out   <= 32'd0;
      load_data <= 32'd0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_FETCH && mem.imem_ready) begin
        instr <= mem.imem_data;
      end
      if (cur_state == S_EXECUTE) begin
        alu_out <= alu_result;
      end
      if (cur_state == S_MEMORY && mem.dmem_ready && should_read_mem) begin
        load_data <= mem.dmem_rdata;
      end
      if (retire_raw) begin
        pc <= pc_next;
      end
    end
  end

  always_comb begin
    nxt_state    = cur_state;
    imem_req_raw = 1'b0;
    dmem_req_raw = 1'b0;
    reg_we_raw   = 1'b0;
    retire_raw   = 1'b0;
    case (cur_state)
      S_FETCH: begin
        imem_req_raw = 1'b1;
        if (mem.imem_ready) begin
          nxt_state = S_DECODE;
        end
      end
      S_DECODE: begin
        nxt_state = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (should_read_mem || should_write_mem) begin
          nxt_state = S_MEMORY;
        end else if (should_write_reg) begin
          nxt_state = S_WRITEBACK;
        end else begin
          retire_raw = 1'b1;
          nxt_state  = S_FETCH;
        end
      end
      S_MEMORY: begin
        dmem_req_raw = 1'b1;
        if (mem.dmem_ready) begin
          if (should_read_mem) begin
            nxt_state = S_WRITEBACK;
          end else begin
            retire_raw = 1'b1;
            nxt_state  = S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        reg_we_raw = 1'b1;
        retire_raw = 1'b1;
        nxt_state  = S_FETCH;
      end
      default: begin
        nxt_state = S_FETCH;
      end
    endcase
  end

  // handshake and strobe outputs are forced low while reset is held
  assign mem.imem_req  = imem_req_raw & ~reset;
  assign mem.imem_addr = pc;
  assign mem.dmem_req  = dmem_req_raw & ~reset;
  assign mem.dmem_we   = mem.dmem_req & should_write_mem & ~should_read_mem;
  assign mem.dmem_addr = alu_out;
  assign reg_we        = reg_we_raw & ~reset;
  assign retire        = retire_raw & ~reset;
  assign wb_sel        = should_read_mem ? WB_SEL_MEM : WB_SEL_ALU;
  assign state         = cur_state;

endmodule

`default_nettype wire

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: table-driven, scoreboard-checked bench for core_sequencer.
// Rev 1.0
`default_nettype none

module tb_core_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct {
    logic [31:0] iword;
    logic        rd, wr, wreg, br, jmp, taken;
    logic [31:0] alu, tgt, rdata;
    int          iw, dw;
    int          cyc, we, dreq;
    logic        dwe, wbsel;
    logic [31:0] pc, npc;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] instr, alu_out, load_data, pc;
  logic        should_read_mem, should_write_mem, should_write_reg;
  logic        should_branch, should_jump, branch_taken;
  logic [31:0] alu_result, target_addr;
  logic        reg_we, wb_sel, retire;
  logic [2:0]  state;

  core_sequencer_if mem ();

  core_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem              (mem.master),
    .instr            (instr),
    .should_read_mem  (should_read_mem),
    .should_write_mem (should_write_mem),
    .should_write_reg (should_write_reg),
    .should_branch    (should_branch),
    .should_jump      (should_jump),
    .alu_result       (alu_result),
    .branch_taken     (branch_taken),
    .target_addr      (target_addr),
    .alu_out          (alu_out),
    .load_data        (load_data),
    .reg_we           (reg_we),
    .wb_sel           (wb_sel),
    .pc               (pc),
    .retire           (retire),
    .state            (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  vec_t        sb[$];
  vec_t        vecs[12];
  logic [31:0] model_pc;
  int          cur_iw = 0, cur_dw = 0;
  logic        mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] iword,
                              input logic rd, wr, wreg, br, jmp, taken,
                              input logic [31:0] alu, tgt, rdata,
                              input int iw, dw, cyc, we, dreq,
                              input logic dwe, wbsel);
    vec_t v;
    v.iword = iword; v.rd = rd; v.wr = wr; v.wreg = wreg; v.br = br; v.jmp = jmp;
    v.taken = taken; v.alu = alu; v.tgt = tgt; v.rdata = rdata; v.iw = iw; v.dw = dw;
    v.cyc = cyc; v.we = we; v.dreq = dreq; v.dwe = dwe; v.wbsel = wbsel;
    v.pc = 32'd0; v.npc = 32'd0;
    return v;
  endfunction

  // memory responder: ready rises after the configured number of wait cycles
  int icnt = 0, dcnt = 0;
  initial begin
    mem.imem_ready = 1'b0; mem.dmem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mem.imem_req) begin mem.imem_ready = (icnt >= cur_iw); icnt++; end
      else begin mem.imem_ready = 1'b0; icnt = 0; end
      if (mem.dmem_req) begin mem.dmem_ready = (dcnt >= cur_dw); dcnt++; end
      else begin mem.dmem_ready = 1'b0; dcnt = 0; end
    end
  end

  // monitor: accumulates per-instruction observations, compares at retire
  int          cyc = 0, wec = 0, dreqc = 0;
  logic        pc_chk = 1'b0, prev_we = 1'b0, prev_ret = 1'b0;
  logic [31:0] chk_pc = 32'd0;
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (pc_chk) begin chk("next_pc", pc, chk_pc); pc_chk = 1'b0; end
      if (sb.size() != 0) begin
        cyc++;
        if (mem.imem_req) chk("imem_addr", mem.imem_addr, sb[0].pc);
        if (state == 3'd1) chk("instr", instr, sb[0].iword);
        if (mem.dmem_req) begin
          dreqc++;
          chk("dmem_addr", mem.dmem_addr, sb[0].alu);
          chk("dmem_we", {31'd0, mem.dmem_we}, {31'd0, sb[0].dwe});
        end
        if (reg_we) begin
          wec++;
          chk("wb_sel", {31'd0, wb_sel}, {31'd0, sb[0].wbsel});
          chk("reg_we_pulse", {31'd0, prev_we}, 32'd0);
        end
        if (retire) begin
          chk("retire_pulse", {31'd0, prev_ret}, 32'd0);
          chk("latency", cyc, sb[0].cyc);
          chk("reg_we_count", wec, sb[0].we);
          chk("dmem_req_cycles", dreqc, sb[0].dreq);
          if (sb[0].rd) chk("load_data", load_data, sb[0].rdata);
          pc_chk = 1'b1;
          chk_pc = sb[0].npc;
          void'(sb.pop_front());
          cyc = 0; wec = 0; dreqc = 0;
        end
      end
    end
    prev_we  = reg_we;
    prev_ret = retire;
  end

  task automatic apply(input vec_t vin);
    vec_t v;
    v = vin;
    should_read_mem  = v.rd;  should_write_mem = v.wr; should_write_reg = v.wreg;
    should_branch    = v.br;  should_jump      = v.jmp; branch_taken    = v.taken;
    alu_result = v.alu; target_addr = v.tgt;
    mem.imem_data = v.iword; mem.dmem_rdata = v.rdata;
    cur_iw = v.iw; cur_dw = v.dw;
    v.pc  = model_pc;
    v.npc = (v.jmp | (v.br & v.taken)) ? {v.tgt[31:2], 2'b00} : model_pc + 32'd4;
    model_pc = v.npc;
    sb.push_back(v);
    for (int k = 0; k < 64 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("retire_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    #1;
  endtask

  initial begin
    //            iword         rd wr wr br jm tk alu            tgt            rdata         iw dw cyc we dq dwe wbs
    vecs[0]  = mk(32'h0050_0093, 0, 0, 1, 0, 0, 0, 32'h0000_0005, 32'h0,         32'h0,         0, 0, 4, 1, 0, 0, 0);
    vecs[1]  = mk(32'h0400_2103, 1, 0, 1, 0, 0, 0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 0, 3, 8, 1, 4, 0, 1);
    vecs[2]  = mk(32'h0000_0063, 0, 0, 0, 1, 0, 1, 32'h0,         32'h0000_0203, 32'h0,         0, 0, 3, 0, 0, 0, 0);
    vecs[3]  = mk(32'h0000_0063, 0, 0, 0, 1, 0, 0, 32'h0,         32'h0000_0303, 32'h0,         0, 0, 3, 0, 0, 0, 0);
    vecs[4]  = mk(32'h0011_2023, 0, 1, 0, 0, 0, 0, 32'h0000_0080, 32'h0,         32'h0,         0, 0, 4, 0, 1, 1, 0);
    vecs[5]  = mk(32'h0780_00EF, 0, 0, 1, 0, 1, 0, 32'h0000_020C, 32'h0000_0080, 32'h0,         0, 0, 4, 1, 0, 0, 0);
    vecs[6]  = mk(32'h0000_000F, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0, 0, 3, 0, 0, 0, 0);
    vecs[7]  = mk(32'h0010_0113, 0, 0, 1, 0, 0, 0, 32'h0000_0001, 32'h0,         32'h0,         2, 0, 6, 1, 0, 0, 0);
    vecs[8]  = mk(32'h0440_2183, 1, 1, 1, 0, 0, 0, 32'h0000_0044, 32'h0,         32'h1234_5678, 0, 0, 5, 1, 1, 0, 1);
    vecs[9]  = mk(32'h0431_2423, 0, 1, 0, 0, 0, 0, 32'h0000_0048, 32'h0,         32'h0,         0, 1, 5, 0, 2, 1, 0);
    vecs[10] = mk(32'hFFFF_F0EF, 0, 0, 1, 0, 1, 0, 32'h0000_0090, 32'hFFFF_FFFE, 32'h0,         0, 0, 4, 1, 0, 0, 0);
    vecs[11] = mk(NOP,           0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0, 0, 4, 1, 0, 0, 0);

    reset = 1'b1;
    should_read_mem = 0; should_write_mem = 0; should_write_reg = 0;
    should_branch = 0; should_jump = 0; branch_taken = 0;
    alu_result = 0; target_addr = 0; mem.imem_data = 0; mem.dmem_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, NOP);
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_imem_req", {31'd0, mem.imem_req}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_pc = RST_PC;
    mon_en = 1'b1;
    for (int i = 0; i < 12; i++) apply(vecs[i]);

    // reset during a stalled data request abandons it immediately
    @(negedge clk); #1;
    mon_en = 1'b0;
    should_read_mem = 1; should_write_mem = 0; should_write_reg = 1;
    should_branch = 0; should_jump = 0; alu_result = 32'h0000_0050;
    mem.imem_data = 32'h0500_2203; cur_iw = 0; cur_dw = 20;
    begin
      int k;
      for (k = 0; k < 32 && state != 3'd3; k++) @(negedge clk);
      chk("reach_memory", {29'd0, state}, 32'd3);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_state_was_mem", {29'd0, state}, 32'd3);
    chk("mid_rst_dmem_req", {31'd0, mem.dmem_req}, 32'd0);
    chk("mid_rst_reg_we", {31'd0, reg_we}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post_rst_state", {29'd0, state}, 32'd0);
    chk("post_rst_pc", pc, RST_PC);
    chk("post_rst_instr", instr, NOP);
    model_pc = RST_PC;
    cyc = 0; wec = 0; dreqc = 0; pc_chk = 1'b0;
    mon_en = 1'b1;
    apply(vecs[0]);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM that sequences the single-issue core datapath through fetch, decode, execute, memory and writeback. It owns the PC, the instruction register, the ALU-result register and the load-data register. It drives the request/ready handshakes to instruction and data memory. It consumes the per-instruction control flags produced by the instruction decoder and asserts register-file write enable and PC update at the correct cycle.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req` out 1, `imem_addr` out 32 (= `pc`), `imem_ready` in 1, `imem_data` in 32: instruction fetch handshake.
- `instr` out 32: instruction register, fed to the decoder.
- `should_read_mem`, `should_write_mem`, `should_write_reg`, `should_branch`, `should_jump` in 1 each: decoder flags, combinational from `instr`.
- `alu_result` in 32: ALU output. `branch_taken` in 1: comparator result. `target_addr` in 32: branch/jump target.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32 (= `alu_out`), `dmem_ready` in 1, `dmem_rdata` in 32: data memory handshake.
- `alu_out` out 32: latched ALU result. `load_data` out 32: latched load word.
- `reg_we` out 1: register-file write enable. `wb_sel` out 1: 0 = `alu_out`, 1 = `load_data`.
- `pc` out 32. `retire` out 1: one-cycle pulse in the last cycle of each instruction. `state` out 3: current FSM state, for debug and verification.

## Operation
- States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4. Encodings 5-7 are unreachable; if reached, the next state is FETCH.
- FETCH
  - `imem_req`=1 and `imem_addr`=`pc`.
  - The request is held until `imem_ready` is sampled high.
  - On that edge: `instr`<=`imem_data`, then go to DECODE.
- DECODE: one cycle; decoder and register-file read settle. Go to EXECUTE.
- EXECUTE: `alu_out`<=`alu_result`. Next state:
  - MEMORY if `should_read_mem` or `should_write_mem`;
  - otherwise WRITEBACK if `should_write_reg`;
  - otherwise retire and go to FETCH.
- MEMORY
  - `dmem_req`=1 and `dmem_we`=`should_write_mem & ~should_read_mem`. Read wins if both flags are set.
  - The request is held until `dmem_ready` is sampled high.
  - Read: `load_data`<=`dmem_rdata`, then go to WRITEBACK.
  - Write: retire and go to FETCH.
- WRITEBACK: `reg_we`=1 for exactly one cycle, with `wb_sel`=`should_read_mem`. Retire and go to FETCH.
- Retire
  - `retire`=1 during the final cycle of the instruction.
  - At the closing edge, `pc` <= `{target_addr[31:2],2'b00}` if `should_jump | (should_branch & branch_taken)`; otherwise `pc`+4.
  - PC arithmetic wraps modulo 2^32; 32'hFFFF_FFFC+4 gives 0.
- `rd`=x0 is not special-cased; the register file discards the write.
- Fence and unknown opcodes (all flags 0) take FETCH, DECODE, EXECUTE and retire.

## Timing
- Reset values:
  - `state`=FETCH, `pc`=`RESET_PC`.
  - `instr`=32'h0000_0013 (NOP). A zero word would decode as a load.
  - `alu_out`=0, `load_data`=0.
- While `reset`=1, `imem_req`, `dmem_req`, `reg_we` and `retire` are forced to 0. These are outputs decoded from `state`, gated with `~reset`.
- Reset mid-transaction abandons the outstanding request with no completion wait. FETCH restarts at `RESET_PC` on the first cycle after reset deasserts.
- Latency with zero-wait memory (`ready` high in the request's first cycle):
  - ALU or jump: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch or fence: 3 cycles.
- Each memory wait cycle adds one cycle.
- `imem_addr` and `dmem_addr`/`dmem_we` are stable for the whole request.
- `reg_we` and `retire` never assert for more than one consecutive cycle.
- Back-to-back instructions: FETCH for instruction N+1 begins in the cycle after `retire` for instruction N.

## Structure
- Shared package `core_pkg`:
  - state localparams (3-bit);
  - `NOP_INSTR`=32'h0000_0013;
  - `WB_SEL_ALU`/`WB_SEL_MEM`.
- Sub-module `pc_next_unit`: combinational next-PC mux (inputs `pc`, `target_addr`, the jump/branch flags; output next PC).
- The FSM, request gating and data registers live in `core_sequencer`.

## Test plan
- Reset with `RESET_PC`=32'h100, then `imem_ready` held high and `imem_data`=ADDI (opcode 0x13): `imem_addr`=0x100 first; `reg_we` in cycle 4; `retire` in cycle 4; next `imem_addr`=0x104.
- Load with `alu_result`=0x40 and `dmem_ready` low for 3 cycles: `dmem_req` high for 4 cycles with `dmem_addr`=0x40 and `dmem_we`=0; then `load_data`=`dmem_rdata`, `reg_we`=1 with `wb_sel`=1; total 8 cycles.
- Taken branch (`branch_taken`=1, `target_addr`=0x203) from `pc`=0x100: no `reg_we`, no `dmem_req`, `retire` in cycle 3, next `pc`=0x200. Repeat not taken: next `pc`=0x104.
- Store then JAL (`target_addr`=0x80): store gives `dmem_we`=1 and no `reg_we`; JAL gives `reg_we`=1 with `wb_sel`=0, and next `pc`=0x80.
- Assert `reset` for 1 cycle during MEMORY with `dmem_req`=1: `dmem_req`=0 in that cycle; `state`=FETCH, `pc`=`RESET_PC`, `instr`=`NOP_INSTR` after the edge.
- `pc`=32'hFFFF_FFFC running a NOP: next `pc`=0.
